// File: rtl/osch_pkg.sv
// Shared types and elaboration-time helpers for the osch oscillator emulation.
// Holds the state enum, the phase increment formula and the startup counter width.
package osch_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  // INC = round(2^acc_w * 2 * nom / ref). The 64-bit product is safe for acc_w up to 32.
  function automatic logic [63:0] calc_inc(input int unsigned ref_khz,
                                           input int unsigned nom_khz,
                                           input int unsigned acc_w);
    logic [63:0] num;
    num = (64'd1 << acc_w) * (64'(nom_khz) * 64'd2);
    return (num + 64'(ref_khz / 2)) / 64'(ref_khz);
  endfunction

  function automatic int cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/osch_phase_acc.sv
// Phase accumulator, carry generation and output toggle flop for osch.
// With OSCH_TICK_EN defined it also produces a registered rising-edge strobe.
module osch_phase_acc #(
  parameter int              ACC_W = 32,
  parameter logic [ACC_W-1:0] INC  = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic osc
`ifdef OSCH_TICK_EN
  ,
  output logic tick
`endif
);

  logic [ACC_W-1:0] acc_reg;
  logic             osc_reg;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_reg} + {1'b0, INC};
  assign osc = osc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      osc_reg <= 1'b0;
    end else if (clr) begin
      acc_reg <= '0;
      osc_reg <= 1'b0;
    end else if (en) begin
      acc_reg <= sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        osc_reg <= ~osc_reg;
      end
    end
  end

`ifdef OSCH_TICK_EN
  logic tick_reg;

  // A carry while osc is low is exactly the edge where osc goes 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= en && !clr && sum[ACC_W] && !osc_reg;
    end
  end

  assign tick = tick_reg;
`endif

endmodule

// File: rtl/osch.sv
// Soft emulation of the on-chip oscillator: fractional divider with standby and startup delay.
// Optional feature macro OSCH_TICK_EN adds the osc_tick rising-edge strobe output.
module osch
  import osch_pkg::*;
#(
  parameter int unsigned REF_FREQ_KHZ   = 100000,
  parameter int unsigned NOM_FREQ_KHZ   = 16630,
  parameter int          ACC_W          = 32,
  parameter int unsigned STARTUP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stdby,
  output logic osc,
  output logic sedstdby
`ifdef OSCH_TICK_EN
  ,
  output logic osc_tick
`endif
);

  localparam int               CNT_W    = cnt_width(STARTUP_CYCLES);
  localparam logic [63:0]      INC_FULL = calc_inc(REF_FREQ_KHZ, NOM_FREQ_KHZ, ACC_W);
  localparam logic [ACC_W-1:0] INC      = INC_FULL[ACC_W-1:0];
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STARTUP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sedstdby_reg;
  logic             acc_en;

  // Standby is honoured on the very edge that samples it, regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WARM;
      cnt_reg      <= CNT_INIT;
      sedstdby_reg <= 1'b1;
    end else if (stdby) begin
      state_reg    <= STOP;
      cnt_reg      <= CNT_INIT;
      sedstdby_reg <= 1'b1;
    end else begin
      case (state_reg)
        STOP: begin
          state_reg    <= WARM;
          sedstdby_reg <= 1'b1;
        end
        WARM: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg    <= RUN;
            sedstdby_reg <= 1'b0;
          end
        end
        RUN: begin
          sedstdby_reg <= 1'b0;
        end
        default: begin
          state_reg    <= STOP;
          cnt_reg      <= CNT_INIT;
          sedstdby_reg <= 1'b1;
        end
      endcase
    end
  end

  assign acc_en   = (state_reg == RUN);
  assign sedstdby = sedstdby_reg;

  osch_phase_acc #(
    .ACC_W (ACC_W),
    .INC   (INC)
  ) u_phase_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc_en),
    .clr   (stdby),
    .osc   (osc)
`ifdef OSCH_TICK_EN
    ,
    .tick  (osc_tick)
`endif
  );

endmodule

// File: tb/tb_osch.sv
// Self-checking bench for osch: a fast (NOM=25 MHz, STARTUP=8) and a default instance
// share stimulus; outputs are compared with constants and a closed-form reference model.
module tb_osch;

  localparam int unsigned REF   = 100000;
  localparam int unsigned NOM_F = 25000;
  localparam int unsigned ST_F  = 8;
  localparam int unsigned NOM_D = 16630;
  localparam int unsigned ST_D  = 16;
  localparam int          FREQ_CYC = 40000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stdby = 1'b0;
  logic osc_f, sed_f, osc_d, sed_d;
`ifdef OSCH_TICK_EN
  logic tick_f, tick_d;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  osch #(
    .REF_FREQ_KHZ   (REF),
    .NOM_FREQ_KHZ   (NOM_F),
    .ACC_W          (32),
    .STARTUP_CYCLES (ST_F)
  ) u_fast (
    .clk      (clk),
    .rst_n    (rst_n),
    .stdby    (stdby),
    .osc      (osc_f),
    .sedstdby (sed_f)
`ifdef OSCH_TICK_EN
    ,
    .osc_tick (tick_f)
`endif
  );

  osch u_dflt (
    .clk      (clk),
    .rst_n    (rst_n),
    .stdby    (stdby),
    .osc      (osc_d),
    .sedstdby (sed_d)
`ifdef OSCH_TICK_EN
    ,
    .osc_tick (tick_d)
`endif
  );

  // Reference model: per instance, track stop/warm status and the number of RUN cycles n.
  // osc is the parity of the number of accumulator wraps, floor(n*INC / 2^32).
  bit              stopped_m [2];
  int unsigned     warm_m    [2];
  longint unsigned n_m       [2];

  function automatic longint unsigned ref_inc(input int unsigned nom);
    return ((64'd1 << 32) * (64'(nom) * 64'd2) + 64'(REF / 2)) / 64'(REF);
  endfunction

  function automatic int unsigned startup_of(input int i);
    return (i == 0) ? ST_F : ST_D;
  endfunction

  function automatic longint unsigned carries(input int i, input longint unsigned n);
    longint unsigned inc;
    inc = (i == 0) ? ref_inc(NOM_F) : ref_inc(NOM_D);
    return (n * inc) >> 32;
  endfunction

  function automatic logic exp_osc(input int i);
    longint unsigned c;
    c = carries(i, n_m[i]);
    return c[0];
  endfunction

  function automatic logic exp_sed(input int i);
    return stopped_m[i] || (warm_m[i] != 0);
  endfunction

  function automatic logic exp_tick(input int i);
    longint unsigned c, p;
    if (n_m[i] == 0) return 1'b0;
    c = carries(i, n_m[i]);
    p = carries(i, n_m[i] - 1);
    return (c != p) && c[0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        stopped_m[i] <= 1'b0;
        warm_m[i]    <= startup_of(i);
        n_m[i]       <= 0;
      end else if (stdby) begin
        stopped_m[i] <= 1'b1;
        warm_m[i]    <= startup_of(i);
        n_m[i]       <= 0;
      end else if (stopped_m[i]) begin
        stopped_m[i] <= 1'b0;
      end else if (warm_m[i] != 0) begin
        warm_m[i] <= warm_m[i] - 1;
      end else begin
        n_m[i] <= n_m[i] + 1;
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  task automatic cmp_model();
    check("model_osc_fast", osc_f, exp_osc(0));
    check("model_sed_fast", sed_f, exp_sed(0));
    check("model_osc_dflt", osc_d, exp_osc(1));
    check("model_sed_dflt", sed_d, exp_sed(1));
`ifdef OSCH_TICK_EN
    check("model_tick_fast", tick_f, exp_tick(0));
    check("model_tick_dflt", tick_d, exp_tick(1));
`endif
  endtask

  typedef struct {
    logic stdby;
    logic osc;
    logic sed;
    logic tick;
  } vec_t;

  vec_t tbl [32];

  initial begin
    int  rises;
    int  exp_rises;
    bit  found;
    logic prev;

    // Fast instance, edge e after reset release (INC = 2^31, STARTUP = 8):
    // WARM for edges 1..8, toggles every 2 edges from edge 10, stdby on edges 19..20.
    for (int e = 1; e <= 32; e++) begin
      tbl[e-1].stdby = (e == 19 || e == 20);
      tbl[e-1].sed   = (e <= 7) || (e >= 19 && e <= 28);
      tbl[e-1].osc   = (e inside {10, 11, 14, 15, 18, 31, 32});
      tbl[e-1].tick  = (e inside {10, 14, 18, 31});
    end

    rst_n = 1'b0;
    stdby = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_osc_fast", osc_f, 1'b0);
    check("reset_sed_fast", sed_f, 1'b1);
    check("reset_osc_dflt", osc_d, 1'b0);
    check("reset_sed_dflt", sed_d, 1'b1);
`ifdef OSCH_TICK_EN
    check("reset_tick_fast", tick_f, 1'b0);
`endif
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++) begin
      stdby = tbl[k].stdby;
      @(negedge clk);
      $display("vec %0d: stdby=%b osc=%b sed=%b", k + 1, stdby, osc_f, sed_f);
      check("tbl_osc", osc_f, tbl[k].osc);
      check("tbl_sed", sed_f, tbl[k].sed);
`ifdef OSCH_TICK_EN
      check("tbl_tick", tick_f, tbl[k].tick);
`endif
      cmp_model();
    end

    // Default instance: stdby for 20 clocks while osc is high.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      cmp_model();
      found = osc_d;
    end
    check("wait_high_dflt", found, 1'b1);
    stdby = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stdby_osc_dflt", osc_d, 1'b0);
      check("stdby_sed_dflt", sed_d, 1'b1);
    end
    stdby = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("warm_sed_dflt", sed_d, 1'b1);
      check("warm_osc_dflt", osc_d, 1'b0);
    end
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      cmp_model();
      found = osc_d;
    end
    check("resume_dflt", found, 1'b1);
    $display("stdby sequence done: osc_d=%b sed_d=%b", osc_d, sed_d);

    // Asynchronous reset between clock edges while osc is high.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = osc_f;
    end
    check("async_pre_high", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_osc_fast", osc_f, 1'b0);
    check("async_sed_fast", sed_f, 1'b1);
    check("async_osc_dflt", osc_d, 1'b0);
    check("async_sed_dflt", sed_d, 1'b1);
    $display("async reset: osc_f=%b sed_f=%b", osc_f, sed_f);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      cmp_model();
    end

    // stdby held through reset release keeps the oscillator stopped.
    rst_n = 1'b0;
    stdby = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("hold_osc_fast", osc_f, 1'b0);
      check("hold_sed_fast", sed_f, 1'b1);
      check("hold_sed_dflt", sed_d, 1'b1);
    end
    $display("stdby through reset: sed_f=%b sed_d=%b", sed_f, sed_d);

    // Randomized standby traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 2) stdby = ~stdby;
      @(negedge clk);
      cmp_model();
    end
    $display("random phase done: %0d checks so far", checks);

    // Long-term rate: rising edges over the run window = run_cycles * NOM / REF (+-1).
    rst_n = 1'b0;
    stdby = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    prev  = osc_d;
    for (int k = 0; k < FREQ_CYC; k++) begin
      @(negedge clk);
      if (osc_d && !prev) rises++;
      prev = osc_d;
      cmp_model();
    end
    exp_rises = int'((64'(FREQ_CYC - int'(ST_D)) * 64'(NOM_D)) / 64'(REF));
    $display("frequency: %0d rising edges, expected %0d", rises, exp_rises);
    check_range("freq_rises_dflt", rises, exp_rises - 1, exp_rises + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
